uart_rx_os: RTL and testbench
=============================

// Module: uart_rx_os
// PURPOSE
//  Oversampling UART receiver; successor to the fixed 8N1 receiver.
//  Samples sin at OVERSAMPLE x baud via baud_tick, reconstructs 5-9 bit frames
//  with optional parity and 1/2 stop bits. Reports errors and hands data to a
//  consumer (FIFO or regfile) over a valid/ready handshake. Sits between the pad and the RX FIFO.
// PARAMETERS
//  DATA_BITS   8   data bits per frame, legal 5..9
//  OVERSAMPLE  16  baud_tick pulses per bit period, even, >=8
//  SYNC_STAGES 2   synchroniser flops on sin, >=2
// PORTS
//  clk          in   1          system clock
//  rst_n        in   1          asynchronous reset, active-low
//  baud_tick    in   1          1-clk strobe at OVERSAMPLE x baud rate
//  parity_en    in   1          1: frame carries a parity bit
//  parity_odd   in   1          1: odd parity; 0: even parity
//  stop2        in   1          1: two stop bits checked
//  sin          in   1          asynchronous serial input, idle high
//  rx_data      out  DATA_BITS  received word, LSB first on the line
//  rx_valid     out  1          rx_data/error flags valid; held until accepted
//  rx_ready     in   1          consumer accepts when rx_valid && rx_ready
//  parity_error out  1          qualified by rx_valid
//  frame_error  out  1          a stop bit sampled low; qualified by rx_valid
//  break_det    out  1          data all 0, parity 0 if present, stop 0; qualified by rx_valid
//  overrun      out  1          1-clk pulse: completed frame dropped, output still held
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, counters 0, sync chain all 1s. Async reset
//   mid-frame aborts the frame. No partial data is ever presented.
//  Settings parity_en/parity_odd/stop2 are sampled on leaving IDLE. Changes mid-frame are ignored.
//  All FSM and counter advances occur only on clk cycles with baud_tick=1.
//  States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   IDLE: synced sin==0 -> START, tick_cnt=0.
//   START: at mid-bit sample (tick_cnt==OVERSAMPLE/2-1), a sample of 0 -> DATA.
//    A sample of 1 means a false start (glitch) -> IDLE, with no flags.
//   DATA: one sample every OVERSAMPLE ticks from mid-start. Shift LSB first.
//    After DATA_BITS samples -> PARITY if parity_en, else STOP.
//   PARITY: computed = ^data ^ parity_odd. Error if the sample differs.
//   STOP: sample stop bit(s) at mid-bit. With stop2, both must be 1.
//    After the last stop mid-sample -> IDLE immediately; this allows a
//    back-to-back start edge in the second half of the stop bit.
//  Completion (the clk after the last stop mid-sample):
//   If !rx_valid, or rx_valid&&rx_ready in the same cycle: load rx_data and
//    the error flags, and set rx_valid=1.
//   Else the frame is discarded and overrun=1 for one clk. Held data is unchanged.
//  rx_valid clears on accept when no completion occurs in that cycle.
//  tick_cnt width: $clog2(OVERSAMPLE). bit_cnt width: $clog2(DATA_BITS+1). Both wrap only via explicit reset to 0.
//  Latency: sin edge -> rx_valid = SYNC_STAGES + frame time - half stop bit + 1 clk.
// CONFIGURATION
//  UART_RX_MAJORITY_EN defined: each bit value is the 2-of-3 majority of the
//   samples at ticks OVERSAMPLE/2-2, -1, 0. The decision is taken at tick OVERSAMPLE/2.
//   Start validation also uses the majority.
//  UART_RX_MAJORITY_EN undefined: single sample at tick OVERSAMPLE/2-1.
//  Ports and flag semantics are identical in both builds.
// STRUCTURE
//  uart_pkg: rx_state_t enum (IDLE,START,DATA,PARITY,STOP) and function
//   parity_calc(data,odd). Shared with the TX side.
//  Sub-module uart_sync (SYNC_STAGES flop chain, reset value 1). Reused by TX/CTS paths.
//  Everything else lives in uart_rx_os: FSM, counters, shift reg, output register.
// TESTING
//  Bench drives sin from a bit-accurate model at OVERSAMPLE=16, with baud_tick every 4 clk.
//  1. 8N1, byte 0xA5, rx_ready=1 -> rx_data=0xA5, rx_valid 1 clk, all flags 0.
//  2. 8E1, 0x03 with parity bit 1 -> parity_error=1, rx_data=0x03.
//     Repeat with parity bit 0 -> no error.
//  3. 8N2, 0x5A, second stop forced 0 -> frame_error=1. Line held 0 for 12 bits -> break_det=1, frame_error=1.
//  4. rx_ready=0, frames 0x11 then 0x22 -> rx_data stays 0x11, overrun pulse at the 2nd
//     completion. Then rx_ready=1 -> accept 0x11, rx_valid=0.
//  5. 3-tick low glitch on idle line -> no rx_valid, FSM back in IDLE.
//     Under UART_RX_MAJORITY_EN, a 1-tick inverted pulse at mid-bit of 0xFF leaves data 0xFF.
//  6. DATA_BITS=9 build, 0x1C3, then rst_n pulsed mid-frame -> outputs 0, next frame 0x055 received clean.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and parity helper.
// Used by the RX side (uart_rx_os) and the TX side.
`timescale 1ns/1ps
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    // Expected parity bit for a word: even parity when odd==0, odd parity when odd==1.
    // Narrower words are zero-extended by the caller, which leaves the XOR unchanged.
    function automatic logic parity_calc(input logic [15:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchroniser for asynchronous single-bit inputs.
// Resets to 1 so an idle-high line does not look like an edge after reset.
`timescale 1ns/1ps
module uart_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the asynchronous input through the flop chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '1;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 5-9 data bits, optional parity, 1 or 2 stop bits,
// error flags and a valid/ready output register.
// Build option: UART_RX_MAJORITY_EN selects 2-of-3 majority sampling per bit.
`timescale 1ns/1ps
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 baud_tick,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 stop2,
    input  logic                 sin,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_error,
    output logic                 frame_error,
    output logic                 break_det,
    output logic                 overrun
);

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] LAST     = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    logic sin_s;
    logic bit_val;

    uart_sync #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (sin),
        .q    (sin_s)
    );

`ifdef UART_RX_MAJORITY_EN
    // Decision one tick later than the single-sample build, so the vote
    // window (mid-2, mid-1, mid) stays centred on the bit.
    localparam logic [TW-1:0] MID = TW'(OVERSAMPLE / 2);
    logic [1:0] hist;

    // Keep the two previous tick samples for the 2-of-3 vote
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= '1;
        end else if (baud_tick) begin
            hist <= {hist[0], sin_s};
        end
    end

    assign bit_val = (hist[1] & hist[0]) | (hist[1] & sin_s) | (hist[0] & sin_s);
`else
    localparam logic [TW-1:0] MID = TW'(OVERSAMPLE / 2 - 1);
    assign bit_val = sin_s;
`endif

    rx_state_t            state;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 cfg_pe;
    logic                 cfg_odd;
    logic                 cfg_stop2;
    logic                 stop_idx;
    logic                 stop0_r;
    logic                 par_bit_r;
    logic                 par_err_r;
    logic                 frm_err_r;
    logic                 brk_r;
    logic                 done;

    // Frame FSM: advances only on baud ticks; done pulses for one clk after the last stop sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            cfg_pe    <= 1'b0;
            cfg_odd   <= 1'b0;
            cfg_stop2 <= 1'b0;
            stop_idx  <= 1'b0;
            stop0_r   <= 1'b0;
            par_bit_r <= 1'b0;
            par_err_r <= 1'b0;
            frm_err_r <= 1'b0;
            brk_r     <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (baud_tick) begin
                case (state)
                    IDLE: begin
                        if (!sin_s) begin
                            state     <= START;
                            tick_cnt  <= '0;
                            cfg_pe    <= parity_en;
                            cfg_odd   <= parity_odd;
                            cfg_stop2 <= stop2;
                        end
                    end
                    START: begin
                        if (tick_cnt == MID) begin
                            tick_cnt <= '0;
                            if (!bit_val) begin
                                state   <= DATA;
                                bit_cnt <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (tick_cnt == LAST) begin
                            tick_cnt <= '0;
                            shift    <= {bit_val, shift[DATA_BITS-1:1]};
                            if (bit_cnt == BIT_LAST) begin
                                bit_cnt   <= '0;
                                stop_idx  <= 1'b0;
                                par_bit_r <= 1'b0;
                                par_err_r <= 1'b0;
                                state     <= cfg_pe ? PARITY : STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    PARITY: begin
                        if (tick_cnt == LAST) begin
                            tick_cnt  <= '0;
                            par_bit_r <= bit_val;
                            par_err_r <= bit_val != parity_calc(16'(shift), cfg_odd);
                            state     <= STOP;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    STOP: begin
                        if (tick_cnt == LAST) begin
                            tick_cnt <= '0;
                            if (cfg_stop2 && !stop_idx) begin
                                stop_idx <= 1'b1;
                                stop0_r  <= bit_val;
                            end else begin
                                state     <= IDLE;
                                done      <= 1'b1;
                                frm_err_r <= !bit_val || (stop_idx && !stop0_r);
                                brk_r     <= (shift == '0) && (!cfg_pe || !par_bit_r)
                                             && !(stop_idx ? stop0_r : bit_val);
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Output register: load on completion when free or being accepted, else flag overrun
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            parity_error <= 1'b0;
            frame_error  <= 1'b0;
            break_det    <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data      <= shift;
                    parity_error <= par_err_r;
                    frame_error  <= frm_err_r;
                    break_det    <= brk_r;
                    rx_valid     <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os: directed frames plus randomized frames,
// expectations from a frame-level model (bit counts, parity by popcount).
`timescale 1ns/1ps
module tb_uart_rx_os;
    import uart_pkg::*;

    localparam int OS     = 16;
    localparam int TPB    = 4;
    localparam int BITCLK = OS * TPB;

    typedef struct {
        int data;
        bit pe;
        bit fe;
        bit bd;
    } frm_t;

    logic       clk = 1'b0;
    logic       rst_n, rst9_n, baud_tick, line, sel9;
    logic       parity_en, parity_odd, stop2, rx_ready, rx_ready9;
    logic       sin8, sin9;
    logic [7:0] rx_data;
    logic [8:0] rx_data9;
    logic       rx_valid, parity_error, frame_error, break_det, overrun;
    logic       rx_valid9, parity_error9, frame_error9, break_det9, overrun9;

    int   checks = 0;
    int   errors = 0;
    int   vcyc8  = 0;
    int   ovr8   = 0;
    frm_t q8[$], q9[$], exp8[$], exp9[$];

    assign sin8 = sel9 ? 1'b1 : line;
    assign sin9 = sel9 ? line : 1'b1;

    uart_rx_os #(.DATA_BITS(8), .OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .parity_en(parity_en),
        .parity_odd(parity_odd), .stop2(stop2), .sin(sin8), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .parity_error(parity_error),
        .frame_error(frame_error), .break_det(break_det), .overrun(overrun)
    );

    uart_rx_os #(.DATA_BITS(9), .OVERSAMPLE(OS), .SYNC_STAGES(2)) dut9 (
        .clk(clk), .rst_n(rst9_n), .baud_tick(baud_tick), .parity_en(parity_en),
        .parity_odd(parity_odd), .stop2(stop2), .sin(sin9), .rx_data(rx_data9),
        .rx_valid(rx_valid9), .rx_ready(rx_ready9), .parity_error(parity_error9),
        .frame_error(frame_error9), .break_det(break_det9), .overrun(overrun9)
    );

    always #5 clk = ~clk;

    initial begin
        baud_tick = 1'b0;
        forever begin
            repeat (TPB - 1) @(posedge clk);
            #1 baud_tick = 1'b1;
            @(posedge clk);
            #1 baud_tick = 1'b0;
        end
    end

    // Consumer-side monitor: record every accepted word, valid cycles and overrun pulses
    always @(negedge clk) begin
        if (rx_valid && rx_ready)
            q8.push_back('{int'(rx_data), parity_error, frame_error, break_det});
        if (rx_valid9 && rx_ready9)
            q9.push_back('{int'(rx_data9), parity_error9, frame_error9, break_det9});
        if (rx_valid) vcyc8++;
        if (overrun) ovr8++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic frm_t model(input int data, input int nb, input bit pe, input bit odd,
                                   input bit pb, input bit s1, input bit s2, input bit st2);
        frm_t m;
        int   ones;
        m.data = data & ((1 << nb) - 1);
        ones   = $countones(m.data);
        m.pe   = pe && (((ones + int'(pb)) % 2) != int'(odd));
        m.fe   = !s1 || (st2 && !s2);
        m.bd   = (m.data == 0) && (!pe || !pb) && !s1;
        return m;
    endfunction

    task automatic idle(input int n);
        line = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Serialise one frame; cut < full length sends only the first cut bits
    task automatic send_frame(input bit nine, input int data, input bit pe, input bit odd,
                              input bit pb, input bit s1, input bit s2, input bit st2,
                              input int cut, input bit keep);
        logic [15:0] d;
        logic [15:0] b;
        int          n;
        int          nb;
        d  = 16'(data);
        nb = nine ? 9 : 8;
        b  = '1;
        b[0] = 1'b0;
        n  = 1;
        for (int i = 0; i < nb; i++) begin
            b[n] = d[i];
            n++;
        end
        if (pe) begin
            b[n] = pb;
            n++;
        end
        b[n] = s1;
        n++;
        if (st2) begin
            b[n] = s2;
            n++;
        end
        if (keep) begin
            if (nine) exp9.push_back(model(data, nb, pe, odd, pb, s1, s2, st2));
            else      exp8.push_back(model(data, nb, pe, odd, pb, s1, s2, st2));
        end
        sel9       = nine;
        parity_en  = pe;
        parity_odd = odd;
        stop2      = st2;
        for (int i = 0; i < n && i < cut; i++) begin
            line = b[i];
            repeat (BITCLK) @(posedge clk);
            #1;
        end
        line = 1'b1;
    endtask

    task automatic check_next(input string tag, input bit nine);
        frm_t o, e;
        if (nine) begin
            chk({tag, "_avail"}, 32'(q9.size() != 0), 32'd1);
            if (q9.size() != 0 && exp9.size() != 0) begin
                o = q9.pop_front();
                e = exp9.pop_front();
            end else return;
        end else begin
            chk({tag, "_avail"}, 32'(q8.size() != 0), 32'd1);
            if (q8.size() != 0 && exp8.size() != 0) begin
                o = q8.pop_front();
                e = exp8.pop_front();
            end else return;
        end
        chk({tag, "_data"}, o.data, e.data);
        chk({tag, "_perr"}, 32'(o.pe), 32'(e.pe));
        chk({tag, "_ferr"}, 32'(o.fe), 32'(e.fe));
        chk({tag, "_brk"},  32'(o.bd), 32'(e.bd));
    endtask

    initial begin
        int v0, o0;
        int dat;
        bit pe, odd, st2, pb, s2;

        line = 1'b1; sel9 = 1'b0; rx_ready = 1'b1; rx_ready9 = 1'b1;
        parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0;
        rst_n = 1'b0; rst9_n = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_valid",   32'(rx_valid), 32'd0);
        chk("rst_data",    32'(rx_data), 32'd0);
        chk("rst_flags",   32'({parity_error, frame_error, break_det, overrun}), 32'd0);
        chk("rst_state",   32'(dut.state), 32'(IDLE));
        chk("rst_valid9",  32'(rx_valid9), 32'd0);
        rst_n = 1'b1; rst9_n = 1'b1;
        idle(20);

        // 8N1 0xA5, rx_valid for exactly one cycle
        v0 = vcyc8;
        send_frame(0, 'hA5, 0, 0, 0, 1, 1, 0, 99, 1);
        idle(BITCLK);
        check_next("t1", 0);
        chk("t1_valid_cycles", 32'(vcyc8 - v0), 32'd1);

        // 8E1 0x03 with wrong then correct parity bit
        send_frame(0, 'h03, 1, 0, 1, 1, 1, 0, 99, 1);
        idle(BITCLK);
        check_next("t2_bad", 0);
        send_frame(0, 'h03, 1, 0, 0, 1, 1, 0, 99, 1);
        idle(BITCLK);
        check_next("t2_good", 0);

        // 8N2 0x5A with second stop low
        send_frame(0, 'h5A, 0, 0, 0, 1, 0, 1, 99, 1);
        idle(BITCLK);
        check_next("t3_ferr", 0);

        // Break: line low for 12 bit times. The still-low line right after the
        // last stop sample starts a new frame whose remaining bits are idle-high.
        parity_en = 1'b0; stop2 = 1'b1;
        exp8.push_back(model(0, 8, 0, 0, 0, 0, 0, 1));
        exp8.push_back(model('hFF, 8, 0, 0, 0, 1, 1, 1));
        line = 1'b0;
        repeat (12 * BITCLK) @(posedge clk);
        #1;
        idle(12 * BITCLK);
        check_next("t3_break", 0);
        check_next("t3_after_break", 0);

        // Randomized frames and settings
        for (int k = 0; k < 10; k++) begin
            dat = int'($urandom_range(0, 255));
            pe  = 1'($urandom_range(0, 1));
            odd = 1'($urandom_range(0, 1));
            st2 = 1'($urandom_range(0, 1));
            pb  = 1'($urandom_range(0, 1));
            s2  = ($urandom_range(0, 3) != 0);
            idle(int'($urandom_range(0, 40)));
            send_frame(0, dat, pe, odd, pb, 1, s2, st2, 99, 1);
            check_next("rand", 0);
        end
        idle(2 * BITCLK);

        // Overrun: consumer stalled across two frames
        rx_ready = 1'b0;
        o0 = ovr8;
        send_frame(0, 'h11, 0, 0, 0, 1, 1, 0, 99, 1);
        send_frame(0, 'h22, 0, 0, 0, 1, 1, 0, 99, 0);
        idle(BITCLK);
        chk("t4_overrun_pulses", 32'(ovr8 - o0), 32'd1);
        chk("t4_held_data",      32'(rx_data), 32'h11);
        chk("t4_held_valid",     32'(rx_valid), 32'd1);
        chk("t4_none_accepted",  32'(q8.size()), 32'd0);
        rx_ready = 1'b1;
        idle(3);
        check_next("t4_accept", 0);
        chk("t4_valid_clear",    32'(rx_valid), 32'd0);

        // Short low glitch on an idle line is rejected
        v0 = vcyc8;
        line = 1'b0;
        repeat (3 * TPB) @(posedge clk);
        #1;
        idle(2 * BITCLK);
        chk("t5_no_valid", 32'(vcyc8 - v0), 32'd0);
        chk("t5_idle",     32'(dut.state), 32'(IDLE));

`ifdef UART_RX_MAJORITY_EN
        // 0xFF with a one-tick low pulse near the middle of data bit 3
        parity_en = 1'b0; stop2 = 1'b0; sel9 = 1'b0;
        exp8.push_back(model('hFF, 8, 0, 0, 0, 1, 1, 0));
        line = 1'b0;
        repeat (BITCLK) @(posedge clk);
        #1;
        idle(3 * BITCLK);
        idle(30);
        line = 1'b0;
        repeat (TPB) @(posedge clk);
        #1;
        idle(BITCLK - 30 - TPB);
        idle(6 * BITCLK);
        idle(BITCLK);
        check_next("t5_majority", 0);
`endif

        // 9-bit build, mid-frame reset, then a clean frame
        send_frame(1, 'h1C3, 0, 0, 0, 1, 1, 0, 99, 1);
        idle(BITCLK);
        check_next("t6_9bit", 1);
        send_frame(1, 'h0AA, 0, 0, 0, 1, 1, 0, 5, 0);
        rst9_n = 1'b0;
        #2;
        chk("t6_rst_valid", 32'(rx_valid9), 32'd0);
        chk("t6_rst_data",  32'(rx_data9), 32'd0);
        chk("t6_rst_flags", 32'({parity_error9, frame_error9, break_det9, overrun9}), 32'd0);
        idle(10);
        rst9_n = 1'b1;
        idle(2 * BITCLK);
        chk("t6_no_partial", 32'(q9.size()), 32'd0);
        send_frame(1, 'h055, 0, 0, 0, 1, 1, 0, 99, 1);
        idle(BITCLK);
        check_next("t6_clean", 1);

        chk("end_q8_empty", 32'(q8.size()), 32'd0);
        chk("end_q9_empty", 32'(q9.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
